// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory req/valid port from a
// running PC and buffers {pc,instr} pairs in a small prefetch FIFO for decode.
//
// Ports:
//   clk           clock, all state on rising edge
//   res           asynchronous active-low reset
//   instr_req     fetch request to memory (registered)
//   instr_addr    fetch byte address (registered, word aligned)
//   instr_valid   memory response valid (only honoured in REQ)
//   instr_read    memory response word
//   redirect      one-cycle pulse: flush and restart at redirect_addr
//   redirect_addr new PC, low two bits dropped
//   out_valid     FIFO head valid
//   out_instr     FIFO head instruction
//   out_pc        FIFO head PC
//   out_ready     decode accepts the head when out_valid is high

`ifndef PC_INIT_ADDR
`define PC_INIT_ADDR 32'h0000_0000
`endif

module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT    = `PC_INIT_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        res,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_valid,
  input  logic [31:0] instr_read,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] fpc_q   [FIFO_DEPTH];
  logic [31:0] finstr_q[FIFO_DEPTH];

  logic push;
  logic pop;
  logic space;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Space uses the registered count only: a pop in the
  // issue cycle is not credited, so a push always fits.
  assign space = (cnt_q < CNT_FULL);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (redirect) begin
      // Abort any in-flight fetch; response and pop
      // arriving this cycle are discarded.
      pc_d     = redirect_addr & ~32'd3;
      req_d    = 1'b0;
      state_d  = DROP;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      pop = (cnt_q != '0) && out_ready;

      unique case (state_q)
        IDLE, DROP: begin
          if (space) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (instr_valid) begin
            push    = 1'b1;
            pc_d    = pc_q + 32'd4;
            req_d   = 1'b0;
            state_d = DROP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      pc_q     <= PC_INIT;
      req_q    <= 1'b0;
      addr_q   <= PC_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // In REQ, pc_q still equals the address being fetched.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fpc_q[i]    <= '0;
        finstr_q[i] <= '0;
      end
    end else if (push) begin
      fpc_q[wr_ptr_q]    <= pc_q;
      finstr_q[wr_ptr_q] <= instr_read;
    end
  end

  assign instr_req  = req_q;
  assign instr_addr = addr_q;
  assign out_valid  = (cnt_q != '0);
  assign out_pc     = fpc_q[rd_ptr_q];
  assign out_instr  = finstr_q[rd_ptr_q];

endmodule
